write_buffer_arbiter: RTL and testbench
=======================================

WRITE_BUFFER_ARBITER -- requirements
Module: write_buffer_arbiter

Interface
REQ-001 Parameter NUM_CH, 4, number of producer channels (2..16).
REQ-002 Parameter DATA_W, 32, width of each channel's write data word.
REQ-003 Parameter TIMEOUT_CYC, 64, maximum stall cycles before abort (only with WRITE_TIMEOUT_EN; range 1..255).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, named as follows:
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 par_done  input  NUM_CH  per-channel one-cycle pulse: word ready to write.
REQ-008 ch_data  input  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W]; held stable while that channel is pending.
REQ-009 ready  input  1  downstream buffer can accept a write.
REQ-010 write_req  output  1  request to the downstream buffer.
REQ-011 write_in_buffer  output  1  one-cycle write strobe.
REQ-012 wr_data  output  DATA_W  registered data of the granted channel.
REQ-013 wr_ch  output  clog2(NUM_CH)  index of the granted channel.
REQ-014 stall_output_buffer  output  NUM_CH  per-channel hold; high while that channel is pending.
REQ-015 ack  output  NUM_CH  one-cycle pulse: the channel's word was written.
REQ-016 timeout_err  output  1  one-cycle pulse: stalled write aborted.

Function
REQ-017 A par_done[i] pulse SHALL set pend[i] on the next edge; pend[i] SHALL clear on the edge where ack[i] or abort for channel i is issued.
REQ-018 If par_done[i] coincides with the clear of pend[i], the set SHALL win (new request retained).
REQ-019 stall_output_buffer SHALL equal pend.
REQ-020 FSM states: IDLE, REQ, STALL, WRITE; outputs decoded from registered state only (Moore).
REQ-021 IDLE: if any pend is set, grant the first set channel at or after rr_ptr (round-robin, wrapping NUM_CH-1 -> 0), latch wr_data and wr_ch, and go to REQ; otherwise stay.
REQ-022 REQ: write_req=1; go to WRITE if ready=1, else go to STALL.
REQ-023 STALL: write_req=1; go to WRITE if ready=1, else stay.
REQ-024 WRITE: write_in_buffer=1 and ack[wr_ch]=1 for exactly one cycle; rr_ptr becomes wr_ch+1 (mod NUM_CH); go to IDLE.
REQ-025 Latency (ready held high): par_done at edge 0 gives pend at edge 1, REQ at edge 2, and WRITE (strobe high) from edge 3 to edge 4.
REQ-026 wr_data and wr_ch SHALL remain unchanged from grant until the FSM returns to IDLE.
REQ-027 At most one channel SHALL be acknowledged per write, and at most one write SHALL occur per 3 cycles.

Reset
REQ-028 While rst=0: state=IDLE, pend=0, rr_ptr=0, wr_data=0, wr_ch=0, timeout counter=0, and all outputs are 0, independent of clk.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon the transfer with no ack and no strobe; the first edge after release evaluates IDLE.

Configuration
REQ-030 Macro WRITE_TIMEOUT_EN defined: an 8-bit counter clears on entry to STALL and increments each STALL cycle.
REQ-031 If the counter reaches TIMEOUT_CYC with ready=0, the FSM SHALL go to IDLE, pulse timeout_err, clear pend[wr_ch] without ack, and advance rr_ptr.
REQ-032 With WRITE_TIMEOUT_EN defined, ready=1 on the timeout cycle SHALL take priority, so the write completes.
REQ-033 Macro undefined: no counter is present, STALL waits indefinitely, and timeout_err is tied to 0.

Verification
REQ-034 Single request, ready=1: par_done[2] at edge 0 -> write_req high in cycle 2, write_in_buffer/ack[2] high in cycle 3, wr_ch=2, wr_data=ch_data[2].
REQ-035 All four channels pulse together, ready=1 -> writes in order 0,1,2,3, one every 3 cycles, each ack exactly once.
REQ-036 ready=0 for 10 cycles after REQ -> write_req and stall_output_buffer[ch] held high, wr_data stable; write 1 cycle after ready rises.
REQ-037 Fairness: ch0 re-pulses immediately after each ack while ch3 pending -> ch3 granted before ch0's second write.
REQ-038 WRITE_TIMEOUT_EN, TIMEOUT_CYC=5, ready=0 -> timeout_err pulse after 5 STALL cycles, no ack, pend cleared; undefined build -> stalls indefinitely.
REQ-039 rst driven low mid-STALL between clock edges -> outputs 0 immediately; after release no ack for the aborted channel.

Source files
------------

// File: rtl/write_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// write_buffer_arbiter
//
// Collects one-cycle "word ready" pulses from NUM_CH producer channels and
// serialises them into single writes to a downstream buffer. Channels are
// served round-robin. A channel stays pending, with its stall line high, until
// its word has been written (or, with the optional timeout, aborted).
//
// Optional feature macro: WRITE_TIMEOUT_EN
//   When defined, a write stalled by ready=0 for TIMEOUT_CYC cycles is aborted.
//   The channel's pending flag is then cleared without an ack, and timeout_err
//   pulses for one cycle. When undefined, a stalled write waits indefinitely.
//
// Parameters
//   NUM_CH       number of producer channels (2..16)
//   DATA_W       width of each channel's data word
//   TIMEOUT_CYC  stall cycles before abort (1..255, timeout build only)
//
// Ports
//   clk                  single clock, rising edge
//   rst                  asynchronous active-low reset
//   par_done  [NUM_CH]   per-channel one-cycle "word ready" pulse
//   ch_data   [NUM_CH*DATA_W] channel i data at [i*DATA_W +: DATA_W]
//   ready                downstream buffer can accept a write
//   write_req            write request to the downstream buffer
//   write_in_buffer      one-cycle write strobe
//   wr_data   [DATA_W]   data of the granted channel
//   wr_ch                index of the granted channel
//   stall_output_buffer  per-channel hold, high while that channel is pending
//   ack       [NUM_CH]   one-cycle pulse: that channel's word was written
//   timeout_err          one-cycle pulse: a stalled write was aborted
// -----------------------------------------------------------------------------
module write_buffer_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            par_done,
    input  logic [NUM_CH*DATA_W-1:0]     ch_data,
    input  logic                         ready,
    output logic                         write_req,
    output logic                         write_in_buffer,
    output logic [DATA_W-1:0]            wr_data,
    output logic [$clog2(NUM_CH)-1:0]    wr_ch,
    output logic [NUM_CH-1:0]            stall_output_buffer,
    output logic [NUM_CH-1:0]            ack,
    output logic                         timeout_err
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t              state_reg;
    logic [NUM_CH-1:0]   pend_reg;
    logic [NUM_CH-1:0]   pend_next;
    logic [CH_W-1:0]     rr_ptr_reg;
    logic [CH_W-1:0]     rr_ptr_adv;
    logic [DATA_W-1:0]   wr_data_reg;
    logic [CH_W-1:0]     wr_ch_reg;
    logic                write_req_reg;
    logic                write_in_buffer_reg;
    logic [NUM_CH-1:0]   ack_reg;
    logic [NUM_CH-1:0]   wr_onehot;
    logic [CH_W-1:0]     grant_ch;
    logic                abort;

`ifdef WRITE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]          to_cnt_reg;
    logic                timeout_err_reg;
`endif

    // One-hot decode of the latched channel, used for ack and pend clearing.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign wr_onehot[gi] = (wr_ch_reg == CH_W'(gi));
        end
    endgenerate

    // Pointer to the channel after the one just served, wrapping to 0.
    assign rr_ptr_adv = (wr_ch_reg == CH_W'(NUM_CH - 1)) ? '0 : wr_ch_reg + 1'b1;

    // Round-robin pick: first pending channel at or after rr_ptr. Offsets are
    // scanned from the far end so the nearest one overwrites the others.
    always_comb begin
        int idx;
        grant_ch = rr_ptr_reg;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (pend_reg[idx]) begin
                grant_ch = CH_W'(idx);
            end
        end
    end

    // Abort fires on the edge where the stall count would reach TIMEOUT_CYC,
    // i.e. after TIMEOUT_CYC cycles spent in STALL. ready=1 always wins.
`ifdef WRITE_TIMEOUT_EN
    assign abort = (state_reg == STALL) && !ready && (to_cnt_reg == TO_LAST);
`else
    assign abort = 1'b0;
`endif

    // Pending flags: clear on write completion or abort, then OR in new pulses
    // so a pulse coinciding with the clear is retained.
    always_comb begin
        pend_next = pend_reg;
        if ((state_reg == WRITE) || abort) begin
            pend_next = pend_reg & ~wr_onehot;
        end
        pend_next = pend_next | par_done;
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg           <= IDLE;
            pend_reg            <= '0;
            rr_ptr_reg          <= '0;
            wr_data_reg         <= '0;
            wr_ch_reg           <= '0;
            write_req_reg       <= 1'b0;
            write_in_buffer_reg <= 1'b0;
            ack_reg             <= '0;
`ifdef WRITE_TIMEOUT_EN
            to_cnt_reg          <= '0;
            timeout_err_reg     <= 1'b0;
`endif
        end else begin
            pend_reg            <= pend_next;
            write_in_buffer_reg <= 1'b0;
            ack_reg             <= '0;
`ifdef WRITE_TIMEOUT_EN
            timeout_err_reg     <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (|pend_reg) begin
                        wr_ch_reg     <= grant_ch;
                        wr_data_reg   <= ch_data[int'(grant_ch)*DATA_W +: DATA_W];
                        write_req_reg <= 1'b1;
                        state_reg     <= REQ;
                    end
                end
                REQ: begin
                    if (ready) begin
                        write_req_reg       <= 1'b0;
                        write_in_buffer_reg <= 1'b1;
                        ack_reg             <= wr_onehot;
                        state_reg           <= WRITE;
                    end else begin
`ifdef WRITE_TIMEOUT_EN
                        to_cnt_reg          <= '0;
`endif
                        state_reg           <= STALL;
                    end
                end
                STALL: begin
                    if (ready) begin
                        write_req_reg       <= 1'b0;
                        write_in_buffer_reg <= 1'b1;
                        ack_reg             <= wr_onehot;
                        state_reg           <= WRITE;
                    end else begin
`ifdef WRITE_TIMEOUT_EN
                        if (abort) begin
                            write_req_reg   <= 1'b0;
                            timeout_err_reg <= 1'b1;
                            rr_ptr_reg      <= rr_ptr_adv;
                            state_reg       <= IDLE;
                        end else begin
                            to_cnt_reg      <= to_cnt_reg + 8'd1;
                        end
`endif
                    end
                end
                WRITE: begin
                    rr_ptr_reg <= rr_ptr_adv;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign write_req           = write_req_reg;
    assign write_in_buffer     = write_in_buffer_reg;
    assign wr_data             = wr_data_reg;
    assign wr_ch               = wr_ch_reg;
    assign stall_output_buffer = pend_reg;
    assign ack                 = ack_reg;
`ifdef WRITE_TIMEOUT_EN
    assign timeout_err         = timeout_err_reg;
`else
    assign timeout_err         = 1'b0;
`endif

endmodule

// File: tb/tb_write_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_write_buffer_arbiter
//
// Directed self-checking bench for write_buffer_arbiter (NUM_CH=4, DATA_W=32,
// TIMEOUT_CYC=5). Inputs change 1 time unit after each rising edge; outputs
// are sampled at the same point. Cycle n below means "after edge n", with the
// par_done pulse driven after edge 0.
// -----------------------------------------------------------------------------
module tb_write_buffer_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int TO_CYC = 5;
`ifdef WRITE_TIMEOUT_EN
    localparam int STALL_LEN = 3;
`else
    localparam int STALL_LEN = 10;
`endif

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         par_done;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic                      ready;
    logic                      write_req;
    logic                      write_in_buffer;
    logic [DATA_W-1:0]         wr_data;
    logic [1:0]                wr_ch;
    logic [NUM_CH-1:0]         stall_output_buffer;
    logic [NUM_CH-1:0]         ack;
    logic                      timeout_err;

    int n_cmp;
    int n_fail;

    write_buffer_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .par_done           (par_done),
        .ch_data            (ch_data),
        .ready              (ready),
        .write_req          (write_req),
        .write_in_buffer    (write_in_buffer),
        .wr_data            (wr_data),
        .wr_ch              (wr_ch),
        .stall_output_buffer(stall_output_buffer),
        .ack                (ack),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input int i);
        return 32'hCAFE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst      = 1'b0;
        par_done = '0;
        ready    = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        par_done = '0;
        ready    = 1'b1;
        #3;
        n_cmp++;
        if ({write_req, write_in_buffer, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000", {write_req, write_in_buffer, timeout_err});
        end
        n_cmp++;
        if ({ack, stall_output_buffer} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_vec: got %h want 00", {ack, stall_output_buffer});
        end
        n_cmp++;
        if ({wr_data, wr_ch} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {wr_data, wr_ch});
        end
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        tick();
        par_done = 4'b0100;
        tick();
        par_done = '0;
        n_cmp++;
        if (stall_output_buffer !== 4'b0100 || write_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1: stall=%b req=%b want 0100/0", stall_output_buffer, write_req);
        end
        tick();
        n_cmp++;
        if (write_req !== 1'b1 || write_in_buffer !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c2: req=%b wib=%b want 1/0", write_req, write_in_buffer);
        end
        tick();
        n_cmp++;
        if (write_in_buffer !== 1'b1 || ack !== 4'b0100 || write_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c3: wib=%b ack=%b req=%b want 1/0100/0", write_in_buffer, ack, write_req);
        end
        n_cmp++;
        if (wr_ch !== 2'd2 || wr_data !== data_of(2)) begin
            n_fail++;
            $display("FAIL single_data: ch=%0d data=%h want 2/%h", wr_ch, wr_data, data_of(2));
        end
        $display("write ch=%0d data=%h", wr_ch, wr_data);
        tick();
        n_cmp++;
        if (ack !== 4'b0000 || stall_output_buffer !== 4'b0000 || write_in_buffer !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c4: ack=%b stall=%b wib=%b want 0", ack, stall_output_buffer, write_in_buffer);
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_CH-1:0] exp_ack;
        logic              exp_req;
        do_reset();
        tick();
        par_done = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) par_done = '0;
            exp_ack = '0;
            if ((c % 3 == 0) && (c <= 12)) exp_ack = 4'b0001 << (c / 3 - 1);
            exp_req = (c % 3 == 2) && (c <= 11);
            n_cmp++;
            if (ack !== exp_ack || write_in_buffer !== (|exp_ack) || write_req !== exp_req) begin
                n_fail++;
                $display("FAIL b2b_c%0d: ack=%b wib=%b req=%b want %b/%b/%b",
                         c, ack, write_in_buffer, write_req, exp_ack, |exp_ack, exp_req);
            end
            if (|exp_ack) begin
                n_cmp++;
                if (wr_ch !== 2'(c / 3 - 1) || wr_data !== data_of(c / 3 - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_data_c%0d: ch=%0d data=%h want %0d/%h",
                             c, wr_ch, wr_data, c / 3 - 1, data_of(c / 3 - 1));
                end
                $display("write ch=%0d data=%h", wr_ch, wr_data);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready = 1'b0;
        tick();
        par_done = 4'b0010;
        tick();
        par_done = '0;
        tick();
        n_cmp++;
        if (write_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_req: got %b want 1", write_req);
        end
        for (int c = 3; c <= 2 + STALL_LEN; c++) begin
            tick();
            n_cmp++;
            if (write_req !== 1'b1 || stall_output_buffer !== 4'b0010 ||
                wr_data !== data_of(1) || write_in_buffer !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_c%0d: req=%b stall=%b data=%h wib=%b want 1/0010/%h/0",
                         c, write_req, stall_output_buffer, wr_data, write_in_buffer, data_of(1));
            end
        end
        ready = 1'b1;
        tick();
        n_cmp++;
        if (write_in_buffer !== 1'b1 || ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_release: wib=%b ack=%b want 1/0010", write_in_buffer, ack);
        end
        $display("write ch=%0d data=%h", wr_ch, wr_data);
    endtask

    task automatic test_fairness();
        logic [NUM_CH-1:0] exp_ack;
        do_reset();
        tick();
        par_done = 4'b1001;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1 || c == 4) par_done = '0;
            exp_ack = (c == 3) ? 4'b0001 : (c == 6) ? 4'b1000 : (c == 9) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("FAIL fair_c%0d: ack=%b want %b", c, ack, exp_ack);
            end
            if (c == 4) begin
                n_cmp++;
                if (stall_output_buffer !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL fair_setwins: stall=%b want 1001", stall_output_buffer);
                end
            end
            if (|exp_ack) $display("write ch=%0d data=%h", wr_ch, wr_data);
            if (c == 3) par_done = 4'b0001;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ready = 1'b0;
        tick();
        par_done = 4'b0100;
        tick();
        par_done = '0;
`ifdef WRITE_TIMEOUT_EN
        for (int c = 2; c <= 7; c++) begin
            tick();
            n_cmp++;
            if (write_req !== 1'b1 || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait_c%0d: req=%b terr=%b want 1/0", c, write_req, timeout_err);
            end
        end
        tick();
        n_cmp++;
        if (timeout_err !== 1'b1 || ack !== 4'b0000 || stall_output_buffer !== 4'b0000 || write_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_abort: terr=%b ack=%b stall=%b req=%b want 1/0000/0000/0",
                     timeout_err, ack, stall_output_buffer, write_req);
        end
        $display("abort ch=%0d", wr_ch);
        tick();
        n_cmp++;
        if (timeout_err !== 1'b0 || write_in_buffer !== 1'b0) begin
            n_fail++;
            $display("FAIL to_after: terr=%b wib=%b want 0/0", timeout_err, write_in_buffer);
        end
`else
        for (int c = 2; c <= 31; c++) tick();
        n_cmp++;
        if (write_req !== 1'b1 || stall_output_buffer !== 4'b0100 || timeout_err !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL no_timeout: req=%b stall=%b terr=%b ack=%b want 1/0100/0/0000",
                     write_req, stall_output_buffer, timeout_err, ack);
        end
`endif
        ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b0;
        tick();
        par_done = 4'b0010;
        tick();
        par_done = '0;
        tick();
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (write_req !== 1'b0 || stall_output_buffer !== 4'b0000 || ack !== 4'b0000 ||
            wr_data !== 32'd0 || wr_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: req=%b stall=%b ack=%b data=%h ch=%0d want all 0",
                     write_req, stall_output_buffer, ack, wr_data, wr_ch);
        end
        #2;
        ready = 1'b1;
        rst   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (ack !== 4'b0000 || write_in_buffer !== 1'b0 || write_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_after_c%0d: ack=%b wib=%b req=%b want 0", c, ack, write_in_buffer, write_req);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        par_done = '0;
        ready    = 1'b1;
        rst      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*DATA_W +: DATA_W] = data_of(i);
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_fairness();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
